sargantana_icache_ifill: RTL and testbench

SARGANTANA_ICACHE_IFILL -- requirements
Module: sargantana_icache_ifill

---
 rtl/sargantana_icache_pkg.sv | 42 ++++
 rtl/sargantana_icache_ifill.sv | 127 ++++++++++++
 tb/tb_sargantana_icache_ifill.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sargantana_icache_pkg.sv
// Shared icache types and constants.
// Line geometry, L2 beat geometry and address field widths live here.
// The icache<->ifill request/response structs are also defined here.
// The fill FSM state enum is defined here as well.
package sargantana_icache_pkg;

    localparam int unsigned PHY_ADDR_SIZE       = 40;
    localparam int unsigned SET_WIDHT           = 512;  // one cache line, in bits
    localparam int unsigned ICACHE_OFFSET_WIDTH = 6;    // 64-byte line
    localparam int unsigned ICACHE_INDEX_WIDTH  = 12;
    localparam int unsigned ICACHE_N_WAY        = 4;
    localparam int unsigned WAY_WIDTH           = $clog2(ICACHE_N_WAY);
    localparam int unsigned L2_BEAT_WIDTH       = 128;
    localparam int unsigned L2_N_BEATS          = SET_WIDHT / L2_BEAT_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } ifill_state_t;

    typedef struct packed {
        logic                          valid;
        logic [WAY_WIDTH-1:0]          way;
        logic [PHY_ADDR_SIZE-1:0]      paddr;
    } ifill_req_o_t;

    typedef struct packed {
        logic                          valid;
        logic [ICACHE_INDEX_WIDTH-1:0] paddr;
    } icache_inv_t;

    typedef struct packed {
        logic                          valid;
        logic                          ack;
        logic [SET_WIDHT-1:0]          data;
        logic [1:0]                    beat;
        icache_inv_t                   inv;
    } ifill_resp_i_t;

endpackage

// File: rtl/sargantana_icache_ifill.sv
// Icache line-fill engine.
// It accepts one fill request from the icache and issues a single line read to L2.
// It assembles the returned beats, which may arrive in any order, into a full line.
// The finished line is handed back to the icache as a one-cycle valid pulse.
// Invalidation requests are forwarded to the icache one cycle later.
//
// Ports:
//   clk_i, rstn_i         clock, synchronous active-low reset
//   ifill_req_i           fill request (valid, way, paddr)
//   ifill_resp_o          fill response (valid, ack, data, beat, inv)
//   l2_req_valid_o/ready_i, l2_req_paddr_o   line-aligned read request to L2
//   l2_resp_valid_i/beat_i/data_i            L2 data beats
//   inv_valid_i, inv_paddr_i                 external invalidation
//
// state | meaning
// IDLE  | waiting for a fill request
// REQ   | L2 request outstanding, waiting for ready
// FILL  | collecting beats until every beat has been seen
// DONE  | line delivered (resp valid high), returning to IDLE
module sargantana_icache_ifill
    import sargantana_icache_pkg::*;
#(
    parameter int unsigned BEAT_WIDTH = L2_BEAT_WIDTH,
    parameter int unsigned N_BEATS    = SET_WIDHT / BEAT_WIDTH
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  ifill_req_o_t                  ifill_req_i,
    output ifill_resp_i_t                 ifill_resp_o,
    output logic                          l2_req_valid_o,
    input  logic                          l2_req_ready_i,
    output logic [PHY_ADDR_SIZE-1:0]      l2_req_paddr_o,
    input  logic                          l2_resp_valid_i,
    input  logic [1:0]                    l2_resp_beat_i,
    input  logic [BEAT_WIDTH-1:0]         l2_resp_data_i,
    input  logic                          inv_valid_i,
    input  logic [ICACHE_INDEX_WIDTH-1:0] inv_paddr_i
);

    ifill_state_t             state_q;
    logic                     ack_q;
    logic                     valid_q;
    logic                     l2_req_valid_q;
    icache_inv_t              inv_q;
    logic [PHY_ADDR_SIZE-1:0] paddr_q;
    logic [WAY_WIDTH-1:0]     way_q;
    logic [SET_WIDHT-1:0]     line_q;
    logic [N_BEATS-1:0]       mask_q;
    logic [N_BEATS-1:0]       beat_onehot;
    logic [N_BEATS-1:0]       mask_nxt;

    always_comb begin
        beat_onehot = '0;
        beat_onehot[l2_resp_beat_i] = 1'b1;
        mask_nxt = mask_q | beat_onehot;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q        <= IDLE;
            mask_q         <= '0;
            ack_q          <= 1'b0;
            valid_q        <= 1'b0;
            l2_req_valid_q <= 1'b0;
            inv_q.valid    <= 1'b0;
        end else begin
            ack_q       <= 1'b0;
            valid_q     <= 1'b0;
            inv_q.valid <= inv_valid_i;
            inv_q.paddr <= inv_paddr_i;

            case (state_q)
                IDLE: begin
                    if (ifill_req_i.valid) begin
                        paddr_q        <= {ifill_req_i.paddr[PHY_ADDR_SIZE-1:ICACHE_OFFSET_WIDTH],
                                           {ICACHE_OFFSET_WIDTH{1'b0}}};
                        way_q          <= ifill_req_i.way;
                        ack_q          <= 1'b1;
                        l2_req_valid_q <= 1'b1;
                        state_q        <= REQ;
                    end
                end
                REQ: begin
                    if (l2_req_ready_i) begin
                        l2_req_valid_q <= 1'b0;
                        state_q        <= FILL;
                    end
                end
                FILL: begin
                    if (l2_resp_valid_i) begin
                        line_q[int'(l2_resp_beat_i)*BEAT_WIDTH +: BEAT_WIDTH] <= l2_resp_data_i;
                        mask_q <= mask_nxt;
                        // valid is raised together with the DONE transition so it
                        // is high exactly while the FSM sits in DONE.
                        if (&mask_nxt) begin
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    mask_q  <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        ifill_resp_o       = '0;
        ifill_resp_o.valid = valid_q;
        ifill_resp_o.ack   = ack_q;
        ifill_resp_o.data  = line_q;
        ifill_resp_o.beat  = 2'(N_BEATS - 1);
        ifill_resp_o.inv   = inv_q;
    end

    assign l2_req_valid_o = l2_req_valid_q;
    assign l2_req_paddr_o = paddr_q;

    // The way is captured for the tag-write path owned by the icache. The
    // offset bits of the request address are discarded by line alignment.
    logic unused_bits;
    assign unused_bits = ^{way_q, ifill_req_i.paddr[ICACHE_OFFSET_WIDTH-1:0]};

endmodule

// File: tb/tb_sargantana_icache_ifill.sv
module tb_sargantana_icache_ifill;
    import sargantana_icache_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                          rstn;
    ifill_req_o_t                  req;
    ifill_resp_i_t                 resp;
    logic                          l2_req_valid;
    logic                          l2_req_ready;
    logic [PHY_ADDR_SIZE-1:0]      l2_req_paddr;
    logic                          l2_resp_valid;
    logic [1:0]                    l2_resp_beat;
    logic [127:0]                  l2_resp_data;
    logic                          inv_valid;
    logic [ICACHE_INDEX_WIDTH-1:0] inv_paddr;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] A0  = 128'h00000000_11111111_22222222_33333333;
    localparam logic [127:0] A1  = 128'h44444444_55555555_66666666_77777777;
    localparam logic [127:0] A2  = 128'h88888888_99999999_AAAAAAAA_BBBBBBBB;
    localparam logic [127:0] A3  = 128'hCCCCCCCC_DDDDDDDD_EEEEEEEE_FFFFFFFF;
    localparam logic [127:0] B0  = 128'h0123_4567_89AB_CDEF_0000_0000_0000_B000;
    localparam logic [127:0] B1  = 128'hDEAD_BEEF_0000_0000_1111_2222_3333_B111;
    localparam logic [127:0] B1X = 128'hFEED_FACE_CAFE_F00D_5555_6666_7777_B1EE;
    localparam logic [127:0] B2  = 128'h2222_0000_2222_0000_2222_0000_2222_B222;
    localparam logic [127:0] B3  = 128'h3333_3333_3333_3333_3333_3333_3333_B333;

    sargantana_icache_ifill dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .ifill_req_i     (req),
        .ifill_resp_o    (resp),
        .l2_req_valid_o  (l2_req_valid),
        .l2_req_ready_i  (l2_req_ready),
        .l2_req_paddr_o  (l2_req_paddr),
        .l2_resp_valid_i (l2_resp_valid),
        .l2_resp_beat_i  (l2_resp_beat),
        .l2_resp_data_i  (l2_resp_data),
        .inv_valid_i     (inv_valid),
        .inv_paddr_i     (inv_paddr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [SET_WIDHT-1:0] obs, input logic [SET_WIDHT-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [1:0] b, input logic [127:0] d);
        l2_resp_valid = 1'b1;
        l2_resp_beat  = b;
        l2_resp_data  = d;
        step();
        l2_resp_valid = 1'b0;
    endtask

    initial begin
        rstn          = 1'b0;
        req           = '0;
        l2_req_ready  = 1'b0;
        l2_resp_valid = 1'b0;
        l2_resp_beat  = 2'd0;
        l2_resp_data  = '0;
        inv_valid     = 1'b0;
        inv_paddr     = '0;
        repeat (3) step();
        chk("rst_ack", resp.ack, 0);
        chk("rst_valid", resp.valid, 0);
        chk("rst_l2v", l2_req_valid, 0);
        chk("rst_inv", resp.inv.valid, 0);
        rstn = 1'b1;
        step();

        // In-order fill, L2 ready immediately.
        req.valid = 1'b1; req.way = 2'd2; req.paddr = 40'h00_8000_1234;
        l2_req_ready = 1'b1;
        step();
        chk("t1_ack", resp.ack, 1);
        chk("t1_l2v", l2_req_valid, 1);
        chk("t1_paddr", l2_req_paddr, 40'h00_8000_1200);
        req.valid = 1'b0;
        step();
        chk("t1_ack_once", resp.ack, 0);
        chk("t1_l2v_drop", l2_req_valid, 0);
        send_beat(2'd0, A0);
        chk("t1_v_b0", resp.valid, 0);
        send_beat(2'd1, A1);
        send_beat(2'd2, A2);
        chk("t1_v_b2", resp.valid, 0);
        send_beat(2'd3, A3);
        chk("t1_valid", resp.valid, 1);
        chk("t1_data", resp.data, {A3, A2, A1, A0});
        chk("t1_beat", resp.beat, 3);
        step();
        chk("t1_v_once", resp.valid, 0);

        // Back-pressure, out-of-order beats, duplicate beat, ignored request.
        l2_req_ready = 1'b0;
        req.valid = 1'b1; req.way = 2'd1; req.paddr = 40'h12_3456_7FFF;
        step();
        chk("t2_ack", resp.ack, 1);
        chk("t2_paddr", l2_req_paddr, 40'h12_3456_7FC0);
        req.valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_l2v_hold", l2_req_valid, 1);
            chk("t2_paddr_hold", l2_req_paddr, 40'h12_3456_7FC0);
        end
        chk("t2_ack_once", resp.ack, 0);
        l2_req_ready = 1'b1;
        step();
        chk("t2_l2v_drop", l2_req_valid, 0);
        l2_req_ready = 1'b0;
        req.valid = 1'b1; req.paddr = 40'h00_0000_1000;
        send_beat(2'd3, B3);
        chk("t2_ack_ign", resp.ack, 0);
        step();
        send_beat(2'd1, B1);
        step();
        send_beat(2'd0, B0);
        chk("t2_v_3of4", resp.valid, 0);
        send_beat(2'd1, B1X);
        chk("t2_v_dup", resp.valid, 0);
        chk("t2_l2v_ign", l2_req_valid, 0);
        req.valid = 1'b0;
        step();
        send_beat(2'd2, B2);
        chk("t2_valid", resp.valid, 1);
        chk("t2_data", resp.data, {B3, B2, B1X, B0});
        step();
        chk("t2_v_once", resp.valid, 0);
        chk("t2_ack_none", resp.ack, 0);
        chk("t2_l2v_none", l2_req_valid, 0);

        // Stray beats while idle are dropped.
        send_beat(2'd0, A0);
        send_beat(2'd1, A1);
        send_beat(2'd2, A2);
        send_beat(2'd3, A3);
        chk("t3_v_stray", resp.valid, 0);
        chk("t3_l2v_stray", l2_req_valid, 0);

        // Reset in the middle of a fill.
        l2_req_ready = 1'b1;
        req.valid = 1'b1; req.way = 2'd0; req.paddr = 40'h00_0000_0040;
        step();
        chk("t4_ack", resp.ack, 1);
        req.valid = 1'b0;
        step();
        send_beat(2'd0, A0);
        send_beat(2'd1, A1);
        rstn = 1'b0;
        step();
        chk("t4_rst_l2v", l2_req_valid, 0);
        chk("t4_rst_valid", resp.valid, 0);
        chk("t4_rst_ack", resp.ack, 0);
        rstn = 1'b1;
        step();
        chk("t4_idle_l2v", l2_req_valid, 0);
        req.valid = 1'b1; req.way = 2'd3; req.paddr = 40'h00_CAFE_BABE;
        step();
        chk("t4_ack2", resp.ack, 1);
        chk("t4_paddr2", l2_req_paddr, 40'h00_CAFE_BA80);
        req.valid = 1'b0;
        step();
        send_beat(2'd2, B2);
        send_beat(2'd3, B3);
        chk("t4_mask_clr", resp.valid, 0);

        // Invalidation passes through one cycle later, mid-fill.
        inv_valid = 1'b1; inv_paddr = 12'h05C;
        send_beat(2'd0, B0);
        inv_valid = 1'b0;
        chk("t5_inv_v", resp.inv.valid, 1);
        chk("t5_inv_pa", resp.inv.paddr, 12'h05C);
        chk("t5_v_3of4", resp.valid, 0);
        send_beat(2'd1, B1);
        chk("t5_inv_drop", resp.inv.valid, 0);
        chk("t5_valid", resp.valid, 1);
        chk("t5_data", resp.data, {B3, B2, B1, B0});
        step();
        chk("t5_v_once", resp.valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
